// File: rtl/psum_ofifo_pkg.sv
// psum_ofifo shared constants and helpers.
// PSUM_BW, default COL/OFIFO_DEPTH, pointer-width function.
package psum_ofifo_pkg;

  localparam int BW          = 4;
  localparam int PSUM_BW     = 2 * BW + 6;
  localparam int COL         = 8;
  localparam int OFIFO_DEPTH = 64;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/psum_fifo_col.sv
// psum_fifo_col: one-column synchronous FIFO, extra pointer MSB for full/empty.
// Ports: clk, reset, wr, rd, din, dout (head, comb), empty, full, ovf_try.
module psum_fifo_col
  import psum_ofifo_pkg::*;
#(
  parameter int bw_psum = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic               rd,
  input  logic [bw_psum-1:0] din,
  output logic [bw_psum-1:0] dout,
  output logic               empty,
  output logic               full,
  output logic               ovf_try
);

  localparam int PW = ptr_w(depth);
  localparam int AW = PW - 1;

  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic [bw_psum-1:0] mem [depth];
  logic               wr_en;
  logic               rd_en;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0])
              && (wptr[AW] != rptr[AW]);

  // full is the pre-edge value: a read in the
  // same cycle does not make room for the write
  assign wr_en   = wr & ~full;
  assign rd_en   = rd & ~empty;
  assign ovf_try = wr & full;
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PW'(1);
      if (rd_en) rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en)
      mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/psum_ofifo.sv
// psum_ofifo: per-column psum FIFOs, releases whole rows via rd/o_valid.
// Ports: clk, reset, in, wr, rd, out, o_out_valid, o_valid, o_full,
// o_ready, o_overflow (sticky only with PSUM_OFIFO_OVF_EN defined).
module psum_ofifo
  import psum_ofifo_pkg::*;
#(
  parameter int col     = COL,
  parameter int bw_psum = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*bw_psum-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*bw_psum-1:0] out,
  output logic                   o_out_valid,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_overflow
);

  logic [col-1:0]         empty;
  logic [col-1:0]         full;
  logic [col-1:0]         ovf_try;
  logic [col*bw_psum-1:0] row;
  logic                   rd_acc;

  assign o_valid = ~|empty;
  assign o_full  = |full;
  assign o_ready = ~o_full;
  assign rd_acc  = rd & o_valid;

  for (genvar i = 0; i < col; i++) begin : g_col
    psum_fifo_col #(
      .bw_psum (bw_psum),
      .depth   (depth)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr[i]),
      .rd      (rd_acc),
      .din     (in[bw_psum*i +: bw_psum]),
      .dout    (row[bw_psum*i +: bw_psum]),
      .empty   (empty[i]),
      .full    (full[i]),
      .ovf_try (ovf_try[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out         <= '0;
      o_out_valid <= 1'b0;
    end else begin
      o_out_valid <= rd_acc;
      if (rd_acc) out <= row;
    end
  end

`ifdef PSUM_OFIFO_OVF_EN
  always_ff @(posedge clk) begin
    if (reset)
      o_overflow <= 1'b0;
    else if (|ovf_try)
      o_overflow <= 1'b1;
  end
`else
  logic unused_ovf;
  assign unused_ovf = |ovf_try;
  assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_psum_ofifo.sv
// tb_psum_ofifo: directed + random stimulus vs per-column queue model.
// Optional overflow flag follows PSUM_OFIFO_OVF_EN.
module tb_psum_ofifo;
  import psum_ofifo_pkg::*;

  localparam int C  = COL;
  localparam int W  = PSUM_BW;
  localparam int D  = OFIFO_DEPTH;
  localparam int DW = C * W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in = '0;
  logic [C-1:0]  wr = '0;
  logic          rd = 1'b0;
  logic [DW-1:0] out;
  logic          o_out_valid;
  logic          o_valid;
  logic          o_full;
  logic          o_ready;
  logic          o_overflow;

  psum_ofifo dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .wr          (wr),
    .rd          (rd),
    .out         (out),
    .o_out_valid (o_out_valid),
    .o_valid     (o_valid),
    .o_full      (o_full),
    .o_ready     (o_ready),
    .o_overflow  (o_overflow)
  );

  always #5 clk = ~clk;

  int            q [C][$];
  logic [DW-1:0] e_out;
  logic          e_ov;
  logic          e_ovf;
  int            n_chk;
  int            n_fail;

  function automatic logic valid_m();
    for (int i = 0; i < C; i++)
      if (q[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic full_m();
    for (int i = 0; i < C; i++)
      if (q[i].size() == D) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] rep(input int v);
    logic [DW-1:0] r;
    for (int i = 0; i < C; i++) r[i*W +: W] = W'(v);
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < C; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("o_valid", DW'(o_valid), DW'(valid_m()));
    chk("o_full", DW'(o_full), DW'(full_m()));
    chk("o_ready", DW'(o_ready), DW'(!full_m()));
    chk("o_out_valid", DW'(o_out_valid), DW'(e_ov));
    chk("out", out, e_out);
    chk("o_overflow", DW'(o_overflow), DW'(e_ovf));
  endtask

  task automatic cyc(input logic [C-1:0] w,
                     input logic [DW-1:0] d,
                     input logic r);
    logic          v;
    logic [C-1:0]  ok;
    logic [DW-1:0] row;
    wr = w;
    in = d;
    rd = r;
    v = valid_m();
    row = '0;
    for (int i = 0; i < C; i++) begin
      ok[i] = w[i] && (q[i].size() < D);
`ifdef PSUM_OFIFO_OVF_EN
      if (w[i] && !ok[i]) e_ovf = 1'b1;
`endif
    end
    @(posedge clk);
    #1;
    if (r && v) begin
      for (int i = 0; i < C; i++)
        row[i*W +: W] = W'(q[i].pop_front());
      e_out = row;
      e_ov = 1'b1;
    end else begin
      e_ov = 1'b0;
    end
    for (int i = 0; i < C; i++)
      if (ok[i]) q[i].push_back(int'(d[i*W +: W]));
    check_all();
    @(negedge clk);
    wr = '0;
    rd = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr = C'($urandom);
    rd = 1'b1;
    in = rnd();
    @(posedge clk);
    #1;
    for (int i = 0; i < C; i++) q[i].delete();
    e_out = '0;
    e_ov = 1'b0;
    e_ovf = 1'b0;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    wr = '0;
    rd = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    n_chk = 0;
    n_fail = 0;
    e_out = '0;
    e_ov = 1'b0;
    e_ovf = 1'b0;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < C; i++) d[i*W +: W] = W'(i + 1);
    cyc('1, d, 1'b0);
    chk("t1_valid", DW'(o_valid), DW'(1));
    cyc('0, '0, 1'b1);
    chk("t1_out", out, d);
    chk("t1_ov", DW'(o_out_valid), DW'(1));
    cyc('0, '0, 1'b0);
    chk("t1_hold", out, d);

    for (int c = 0; c < C; c++) begin
      cyc(C'(1 << c), rnd(), c == 5);
      chk("t2_valid", DW'(o_valid), DW'(c == C - 1));
    end
    cyc('0, '0, 1'b1);

    for (int k = 0; k < D; k++) cyc('1, rep(k), 1'b0);
    chk("t3_full", DW'(o_full), DW'(1));
    cyc('1, rnd(), 1'b0);
    for (int k = 0; k < D; k++) begin
      cyc('0, '0, 1'b1);
      chk("t3_out", out, rep(k));
    end
    chk("t3_empty", DW'(o_valid), DW'(0));

    do_reset();
    for (int k = 0; k < 10; k++) cyc('1, rep(k + 100), 1'b0);
    for (int k = 0; k < 100; k++) begin
      cyc('1, rnd(), 1'b1);
      chk("t4_nofull", DW'(o_full), DW'(0));
    end

    do_reset();
    for (int k = 0; k < D; k++) cyc('1, rnd(), 1'b0);
    cyc('1, rep(5555), 1'b1);
    chk("t5_notfull", DW'(o_full), DW'(0));
    cyc('1, rnd(), 1'b0);
    chk("t5_full", DW'(o_full), DW'(1));
    for (int k = 0; k < D; k++) cyc('0, '0, 1'b1);

    do_reset();
    for (int k = 0; k < 20; k++) cyc('1, rnd(), 1'b0);
    do_reset();
    cyc('1, rep(777), 1'b0);
    cyc('0, '0, 1'b1);
    chk("t6_out", out, rep(777));
    cyc('0, '0, 1'b1);
    chk("t6_ov", DW'(o_out_valid), DW'(0));

    for (int k = 0; k < 400; k++)
      cyc(C'($urandom), rnd(), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
